// File: rtl/lstm_dense_output.sv
// Fully-connected output stage behind the LSTM network: y = Wy*h + by.
// The hidden vector is captured on hiddenValid. One serial signed MAC walks
// every row, and each row is rounded (half toward +inf) and saturated back to
// Q(QN).(QM). The finished vector is published with a one-cycle outputValid.
module lstm_dense_output #(
  parameter  int HIDDEN_SZ       = 8,
  parameter  int OUTPUT_SZ       = 1,
  parameter  int QN              = 6,
  parameter  int QM              = 11,
  localparam int BITWIDTH        = QN + QM + 1,
  localparam int LAYER_BITWIDTH  = BITWIDTH * HIDDEN_SZ,
  localparam int OUTPUT_BITWIDTH = BITWIDTH * OUTPUT_SZ,
  localparam int HADDR           = $clog2(HIDDEN_SZ),
  localparam int OADDR           = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1,
  localparam int ACC_W           = 2 * BITWIDTH + HADDR + 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [LAYER_BITWIDTH-1:0]  hiddenVec,
  input  logic                       hiddenValid,
  input  logic                       wrEn,
  input  logic                       wrBias,
  input  logic [OADDR-1:0]           wrRow,
  input  logic [HADDR-1:0]           wrCol,
  input  logic [BITWIDTH-1:0]        wrData,
  output logic [OUTPUT_BITWIDTH-1:0] outputVec,
  output logic                       outputValid,
  output logic                       busy,
  output logic                       droppedSample
);

  // Storage is sized to the full row address space, so any wrRow/row value
  // indexes a real entry. Rows at or above OUTPUT_SZ are never written or used.
  localparam int ROWS = 1 << OADDR;

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (QM - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = (ACC_W'(1) << (BITWIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_DONE} state_t;

  state_t state, state_nxt;

  logic signed [BITWIDTH-1:0] wy   [ROWS][HIDDEN_SZ];
  logic signed [BITWIDTH-1:0] by   [ROWS];
  logic signed [BITWIDTH-1:0] hbuf [HIDDEN_SZ];
  logic signed [BITWIDTH-1:0] slot [ROWS];

  logic [OADDR-1:0]        row;
  logic [OADDR-1:0]        row_nxt;
  logic [HADDR-1:0]        col;
  logic signed [ACC_W-1:0] acc;

  logic last_col;
  logic last_row;
  logic do_start;
  logic do_mac;
  logic do_round;
  logic do_done;
  logic coef_wr;

  logic signed [BITWIDTH-1:0]   bias_first;
  logic signed [2*BITWIDTH-1:0] prod;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W-1:0]      acc_rnd;
  logic signed [ACC_W-1:0]      acc_shr;
  logic signed [BITWIDTH-1:0]   sat_val;
  logic [OUTPUT_BITWIDTH-1:0]   result_vec;

  // A bias enters the accumulator at the product scale: sign-extend it, then shift up by QM.
  function automatic logic signed [ACC_W-1:0] bias_to_acc(input logic signed [BITWIDTH-1:0] b);
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W - BITWIDTH){b[BITWIDTH-1]}}, b};
    return ext <<< QM;
  endfunction

  assign last_col = (col == HADDR'(HIDDEN_SZ - 1));
  assign last_row = (row == OADDR'(OUTPUT_SZ - 1));
  assign row_nxt  = last_row ? row : row + OADDR'(1);

  // State register.
  // NOTE: clocked processes use non-blocking (<=) assignments only. Every
  // register then samples pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one MAC pass per row, then a ROUND. DONE follows the last row.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (hiddenValid) state_nxt = S_MAC;
      S_MAC:   if (last_col)    state_nxt = S_ROUND;
      S_ROUND: state_nxt = last_row ? S_DONE : S_MAC;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control decode. Coefficients may only change in IDLE, so a sample in flight always sees one weight set.
  always_comb begin
    do_start = (state == S_IDLE) && hiddenValid;
    do_mac   = (state == S_MAC);
    do_round = (state == S_ROUND);
    do_done  = (state == S_DONE);
    coef_wr  = (state == S_IDLE) && wrEn && (int'(wrRow) < OUTPUT_SZ);
  end

  // Datapath arithmetic: product, rounding, saturation, and by[0] bypass for a write that lands with the capture.
  always_comb begin
    prod       = wy[row][col] * hbuf[col];
    prod_ext   = {{(ACC_W - 2 * BITWIDTH){prod[2*BITWIDTH-1]}}, prod};
    acc_rnd    = acc + RND_HALF;
    acc_shr    = acc_rnd >>> QM;
    sat_val    = acc_shr[BITWIDTH-1:0];
    if (acc_shr > SAT_MAX) sat_val = SAT_MAX[BITWIDTH-1:0];
    if (acc_shr < SAT_MIN) sat_val = SAT_MIN[BITWIDTH-1:0];
    bias_first = (coef_wr && wrBias && (wrRow == '0)) ? wrData : by[0];
  end

  // Pack the finished row results into the output bus layout.
  always_comb begin
    result_vec = '0;
    for (int k = 0; k < OUTPUT_SZ; k++) begin
      result_vec[k*BITWIDTH +: BITWIDTH] = slot[k];
    end
  end

  // Coefficient storage and hidden-vector capture.
  // NOTE: these arrays have no reset. Coefficients must survive a reset, and
  // the capture buffer is always written before it is read.
  always_ff @(posedge clock) begin
    if (coef_wr) begin
      if (wrBias) by[wrRow]        <= wrData;
      else        wy[wrRow][wrCol] <= wrData;
    end
    if (do_start) begin
      for (int j = 0; j < HIDDEN_SZ; j++) begin
        hbuf[j] <= hiddenVec[j*BITWIDTH +: BITWIDTH];
      end
    end
  end

  // Sequencing, accumulation, result slots and the published output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row           <= '0;
      col           <= '0;
      acc           <= '0;
      outputVec     <= '0;
      outputValid   <= 1'b0;
      busy          <= 1'b0;
      droppedSample <= 1'b0;
      for (int k = 0; k < ROWS; k++) slot[k] <= '0;
    end else begin
      outputValid <= 1'b0;
      if (hiddenValid && (state != S_IDLE)) droppedSample <= 1'b1;
      if (do_start) begin
        row  <= '0;
        col  <= '0;
        acc  <= bias_to_acc(bias_first);
        busy <= 1'b1;
      end
      if (do_mac) begin
        acc <= acc + prod_ext;
        col <= col + HADDR'(1);
      end
      if (do_round) begin
        slot[row] <= sat_val;
        if (!last_row) begin
          row <= row_nxt;
          col <= '0;
          acc <= bias_to_acc(by[row_nxt]);
        end
      end
      if (do_done) begin
        outputVec   <= result_vec;
        outputValid <= 1'b1;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lstm_dense_output.sv
// Self-checking bench for lstm_dense_output. A default build (one output) and
// a two-output build are driven with directed and $urandom stimulus. Results
// are compared with a plain-arithmetic model of y = Wy*h + by that rounds half
// toward +inf and saturates.
module tb_lstm_dense_output;
  localparam int HID  = 8;
  localparam int QN   = 6;
  localparam int QM   = 11;
  localparam int BW   = QN + QM + 1;
  localparam int SMAX = (1 << (BW - 1)) - 1;
  localparam int SMIN = -(1 << (BW - 1));

  typedef int vec_t [HID];

  logic              clock = 1'b0;
  logic              reset;
  logic [BW*HID-1:0] hiddenVec;
  logic              hiddenValid;
  logic              wrEn;
  logic              wrBias;
  logic [0:0]        wrRow;
  logic [2:0]        wrCol;
  logic [BW-1:0]     wrData;
  logic [BW-1:0]     outputVec;
  logic              outputValid;
  logic              busy;
  logic              droppedSample;

  logic              hiddenValid2;
  logic              wrEn2;
  logic [0:0]        wrRow2;
  logic [2*BW-1:0]   outputVec2;
  logic              outputValid2;
  logic              busy2;
  logic              droppedSample2;

  int vectors     = 0;
  int miscompares = 0;

  vec_t m1_wy;
  int   m1_by;
  vec_t m2_wy [2];
  int   m2_by [2];

  lstm_dense_output dut (
    .clock(clock), .reset(reset), .hiddenVec(hiddenVec), .hiddenValid(hiddenValid),
    .wrEn(wrEn), .wrBias(wrBias), .wrRow(wrRow), .wrCol(wrCol), .wrData(wrData),
    .outputVec(outputVec), .outputValid(outputValid), .busy(busy),
    .droppedSample(droppedSample)
  );

  lstm_dense_output #(.OUTPUT_SZ(2)) dut2 (
    .clock(clock), .reset(reset), .hiddenVec(hiddenVec), .hiddenValid(hiddenValid2),
    .wrEn(wrEn2), .wrBias(wrBias), .wrRow(wrRow2), .wrCol(wrCol), .wrData(wrData),
    .outputVec(outputVec2), .outputValid(outputValid2), .busy(busy2),
    .droppedSample(droppedSample2)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision sum, round half toward +inf, clamp to the Q format.
  function automatic int ref_out(input vec_t w, input int b, input vec_t h);
    longint acc;
    longint r;
    acc = longint'(b) * (longint'(1) << QM);
    for (int i = 0; i < HID; i++) acc += longint'(w[i]) * longint'(h[i]);
    r = (acc + (longint'(1) << (QM - 1))) >>> QM;
    if (r > SMAX) r = SMAX;
    if (r < SMIN) r = SMIN;
    return int'(r);
  endfunction

  function automatic logic [BW-1:0] q(input int x);
    return BW'(x);
  endfunction

  function automatic logic [BW*HID-1:0] pack(input vec_t h);
    logic [BW*HID-1:0] v;
    for (int j = 0; j < HID; j++) v[j*BW +: BW] = BW'(h[j]);
    return v;
  endfunction

  function automatic int rnd(input int mag);
    return int'($urandom_range(2 * mag)) - mag;
  endfunction

  task automatic rvec(output vec_t h, input int mag);
    for (int j = 0; j < HID; j++) h[j] = rnd(mag);
  endtask

  task automatic drive_wr(input bit b, input int row, input int col, input int data);
    wrEn   = 1'b1;
    wrBias = b;
    wrRow  = 1'(row);
    wrCol  = 3'(col);
    wrData = BW'(data);
  endtask

  // Idle-time write to the one-output DUT; the model takes it only for an existing row.
  task automatic wr1(input bit b, input int row, input int col, input int data);
    drive_wr(b, row, col, data);
    @(negedge clock);
    wrEn = 1'b0;
    if (row < 1) begin
      if (b) m1_by = data;
      else   m1_wy[col] = data;
    end
  endtask

  task automatic wr2(input bit b, input int row, input int col, input int data);
    wrEn2  = 1'b1;
    wrBias = b;
    wrRow2 = 1'(row);
    wrCol  = 3'(col);
    wrData = BW'(data);
    @(negedge clock);
    wrEn2 = 1'b0;
    if (b) m2_by[row] = data;
    else   m2_wy[row][col] = data;
  endtask

  task automatic set1(input int w, input int b);
    for (int j = 0; j < HID; j++) wr1(1'b0, 0, j, w);
    wr1(1'b1, 0, 0, b);
  endtask

  task automatic setrand1(input int wmag, input int bmag);
    for (int j = 0; j < HID; j++) wr1(1'b0, 0, j, rnd(wmag));
    wr1(1'b1, 0, 0, rnd(bmag));
  endtask

  // Capture h, then watch 26 cycles (c = 0 is the cycle right after the
  // capture edge). Optional events: a second hiddenValid with h2 at cycle
  // pulse_at, a write at cycle write_at (-2: in the capture cycle), and a
  // one-cycle reset at cycle reset_at.
  task automatic run1(input vec_t h, input vec_t h2, input int pulse_at,
                      input int write_at, input bit w_bias, input int w_col, input int w_data,
                      input int reset_at,
                      output int n_valid, output int lat, output logic [BW-1:0] v1,
                      output logic [BW-1:0] v2, output int bcnt);
    vec_t junk;
    n_valid = 0; lat = -1; v1 = '0; v2 = '0; bcnt = 0;
    hiddenVec   = pack(h);
    hiddenValid = 1'b1;
    if (write_at == -2) drive_wr(w_bias, 0, w_col, w_data);
    @(negedge clock);
    hiddenValid = 1'b0;
    wrEn        = 1'b0;
    rvec(junk, SMAX);
    hiddenVec   = pack(junk);
    for (int c = 0; c < 26; c++) begin
      if (busy) bcnt++;
      if (outputValid) begin
        n_valid++;
        if (n_valid == 1) begin
          lat = c;
          v1  = outputVec;
        end else begin
          v2 = outputVec;
        end
      end
      if (c == pulse_at) begin
        hiddenVec   = pack(h2);
        hiddenValid = 1'b1;
      end
      if (c == write_at) drive_wr(w_bias, 0, w_col, w_data);
      if (c == reset_at) reset = 1'b0;
      @(negedge clock);
      hiddenValid = 1'b0;
      wrEn        = 1'b0;
      reset       = 1'b1;
    end
  endtask

  task automatic expect_single(input string tag, input int nv, input int lat,
                               input logic [BW-1:0] v, input int e);
    check({tag, "_count"}, nv, 1);
    check({tag, "_latency"}, lat, 10);
    check({tag, "_value"}, v, q(e));
  endtask

  initial begin
    vec_t h;
    vec_t h2;
    int nv;
    int lat;
    int bc;
    int e;
    int e2;
    int old_w;
    logic [BW-1:0]   v1;
    logic [BW-1:0]   v2;
    logic [2*BW-1:0] vv;

    reset = 1'b0; hiddenVec = '0; hiddenValid = 1'b0;
    wrEn = 1'b0; wrBias = 1'b0; wrRow = '0; wrCol = '0; wrData = '0;
    hiddenValid2 = 1'b0; wrEn2 = 1'b0; wrRow2 = '0;
    m1_by = 0; m2_by[0] = 0; m2_by[1] = 0;
    for (int j = 0; j < HID; j++) begin
      m1_wy[j] = 0; m2_wy[0][j] = 0; m2_wy[1][j] = 0;
    end
    repeat (3) @(negedge clock);
    check("rst_outputVec", outputVec, 0);
    check("rst_outputValid", outputValid, 0);
    check("rst_busy", busy, 0);
    check("rst_droppedSample", droppedSample, 0);
    check("rst_outputVec2", outputVec2, 0);
    reset = 1'b1;
    @(negedge clock);

    // Basic MAC: 8 * (1.0 * 0.5) = 4.0.
    set1(2048, 0);
    for (int j = 0; j < HID; j++) h[j] = 1024;
    run1(h, h, -1, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("basic", nv, lat, v1, 8192);
    check("basic_busy_cycles", bc, 10);
    check("basic_pulse_low", outputValid, 0);
    check("basic_hold", outputVec, 8192);

    // Bias plus half an LSB rounds up; minus half an LSB stays.
    set1(0, 2048);
    wr1(1'b0, 0, 0, 1024);
    rvec(h, SMAX);
    h[0] = 1;
    run1(h, h, -1, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("round_up", nv, lat, v1, 2049);
    h[0] = -1;
    run1(h, h, -1, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("round_half_down", nv, lat, v1, 2048);

    // Saturation at both rails.
    set1(63488, 0);
    for (int j = 0; j < HID; j++) h[j] = 63488;
    run1(h, h, -1, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("sat_pos", nv, lat, v1, 131071);
    set1(-63488, 0);
    run1(h, h, -1, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("sat_neg", nv, lat, v1, -131072);
    check("sat_neg_bits", v1, 18'h20000);

    // Random coefficients and inputs.
    for (int t = 0; t < 4; t++) begin
      setrand1(4096, 65536);
      rvec(h, 8192);
      e = ref_out(m1_wy, m1_by, h);
      run1(h, h, -1, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
      expect_single("random", nv, lat, v1, e);
    end

    // Writes to a non-existent row must not disturb row 0.
    wr1(1'b0, 1, 0, rnd(4096));
    wr1(1'b1, 1, 0, rnd(65536));
    rvec(h, 2048);
    e = ref_out(m1_wy, m1_by, h);
    run1(h, h, -1, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("oor_write", nv, lat, v1, e);

    // Writes landing in the capture cycle are used by that sample.
    m1_by = m1_by + 5000;
    e = ref_out(m1_wy, m1_by, h);
    run1(h, h, -1, -2, 1'b1, 0, m1_by, -1, nv, lat, v1, v2, bc);
    expect_single("cap_bias_write", nv, lat, v1, e);
    h[3] = 2048;
    m1_wy[3] = m1_wy[3] + 1000;
    e = ref_out(m1_wy, m1_by, h);
    run1(h, h, -1, -2, 1'b0, 3, m1_wy[3], -1, nv, lat, v1, v2, bc);
    expect_single("cap_weight_write", nv, lat, v1, e);

    // A write while busy is dropped; the same write issued in IDLE takes effect.
    h[0]  = 2048;
    old_w = m1_wy[0];
    e = ref_out(m1_wy, m1_by, h);
    run1(h, h, -1, 3, 1'b0, 0, old_w + 1000, -1, nv, lat, v1, v2, bc);
    expect_single("busy_write", nv, lat, v1, e);
    run1(h, h, -1, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("busy_write_readback", nv, lat, v1, e);
    wr1(1'b0, 0, 0, old_w + 1000);
    e2 = ref_out(m1_wy, m1_by, h);
    run1(h, h, -1, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("idle_write", nv, lat, v1, e2);

    // Overlapping hiddenValid is dropped and flagged; the next sample is accepted normally.
    rvec(h, 2048);
    rvec(h2, 2048);
    e = ref_out(m1_wy, m1_by, h);
    run1(h, h2, 2, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("overlap", nv, lat, v1, e);
    check("overlap_dropped", droppedSample, 1);
    rvec(h, 2048);
    e = ref_out(m1_wy, m1_by, h);
    run1(h, h, -1, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("after_overlap", nv, lat, v1, e);

    // Reset in the middle of MAC aborts cleanly and keeps the coefficients.
    run1(h, h, -1, -1, 1'b0, 0, 0, 4, nv, lat, v1, v2, bc);
    check("midreset_count", nv, 0);
    check("midreset_outputVec", outputVec, 0);
    check("midreset_dropped", droppedSample, 0);
    check("midreset_busy", busy, 0);
    rvec(h, 2048);
    e = ref_out(m1_wy, m1_by, h);
    run1(h, h, -1, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("after_reset", nv, lat, v1, e);

    // hiddenValid during DONE is rejected; one cycle later it is accepted.
    rvec(h, 2048);
    rvec(h2, 2048);
    e  = ref_out(m1_wy, m1_by, h);
    e2 = ref_out(m1_wy, m1_by, h2);
    run1(h, h2, 9, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    expect_single("done_cycle_reject", nv, lat, v1, e);
    check("done_cycle_dropped", droppedSample, 1);
    run1(h, h2, 10, -1, 1'b0, 0, 0, -1, nv, lat, v1, v2, bc);
    check("b2b_count", nv, 2);
    check("b2b_first", v1, q(e));
    check("b2b_second", v2, q(e2));

    // Two-output build: distinct rows, 19-cycle latency.
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < 2; r++) begin
        for (int j = 0; j < HID; j++) wr2(1'b0, r, j, rnd(4096));
        wr2(1'b1, r, 0, rnd(65536));
      end
      rvec(h, 8192);
      hiddenVec    = pack(h);
      hiddenValid2 = 1'b1;
      @(negedge clock);
      hiddenValid2 = 1'b0;
      rvec(h2, SMAX);
      hiddenVec = pack(h2);
      lat = -1;
      vv  = '0;
      for (int c = 0; c < 30; c++) begin
        if (outputValid2 && (lat < 0)) begin
          lat = c;
          vv  = outputVec2;
        end
        @(negedge clock);
      end
      check("multi_latency", lat, 19);
      check("multi_row0", vv[BW-1:0], q(ref_out(m2_wy[0], m2_by[0], h)));
      check("multi_row1", vv[2*BW-1:BW], q(ref_out(m2_wy[1], m2_by[1], h)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
